// File: rtl/pdm_word_fifo.sv
// pdm_word_fifo: first-word-fall-through sample buffer between the PDM capture
// engine and the AHB read path. It holds up to 2**AW packed PDM words and
// reports level, empty/full, sticky overflow/underflow and a level-threshold
// interrupt.
//
// Handshake: there is no back-pressure. wr_valid is a one-cycle push strobe
// that is accepted when the buffer is not full, or when a pop is accepted in
// the same cycle. If the buffer is full it is dropped and flagged as overflow.
// rd_en is a one-cycle pop strobe that is accepted when the buffer is not
// empty. If the buffer is empty it is ignored and flagged as underflow.
// rd_data always shows the head word.
module pdm_word_fifo #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          g_hclk_es1,
    input  logic          hreset_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    input  logic          flush,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic          irq_level
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_THR  = (AW+1)'(THRESH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic          push_ok;
    logic          pop_ok;

    // Status is decoded from the registered level, so it is glitch-free.
    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign rd_data = mem[rd_ptr];

    // Pop is evaluated first, because an accepted pop frees a slot for a push while full.
    assign pop_ok  = rd_en & ~empty;
    assign push_ok = wr_valid & (~full | pop_ok);

    // Compute the next fill level from the accepted push and pop.
    always_comb begin
        level_nxt = level;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    // Write the storage array. It is not reset, because stale words are never
    // visible once level is zero.
    always_ff @(posedge g_hclk_es1) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Update pointers, level, sticky flags and the threshold interrupt. Flush
    // overrides push and pop in the same cycle.
    always_ff @(posedge g_hclk_es1 or negedge hreset_n) begin
        if (!hreset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq_level <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq_level <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_nxt;
            if (wr_valid && !push_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            irq_level <= (level_nxt >= LVL_THR);
        end
    end

endmodule

// File: tb/tb_pdm_word_fifo.sv
// Testbench for pdm_word_fifo. A directed vector table is followed by
// hand-written sequences for the multi-cycle corner cases (fill, wrap,
// overflow, threshold, flush, reset mid-stream). A queue scoreboard holds the
// expected contents.
module tb_pdm_word_fifo;

    logic        g_hclk_es1;
    logic        hreset_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        flush;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic        irq_level;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        re;
        logic        fl;
        logic [4:0]  lvl;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
        logic        irq;
        logic        chk_d;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[9];

    pdm_word_fifo #(.DW(32), .AW(4), .THRESH(8)) dut (
        .g_hclk_es1 (g_hclk_es1),
        .hreset_n   (hreset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .flush      (flush),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .irq_level  (irq_level)
    );

    // Clock and reset generation.
    initial g_hclk_es1 = 1'b0;
    always #5 g_hclk_es1 = ~g_hclk_es1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare every status output against the scoreboard.
    task automatic check_status(input string tag);
        check({tag, " level"},     32'(level),     32'(exp_q.size()));
        check({tag, " empty"},     32'(empty),     32'(exp_q.size() == 0));
        check({tag, " full"},      32'(full),      32'(exp_q.size() == 16));
        check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
        check({tag, " irq_level"}, 32'(irq_level), 32'(exp_q.size() >= 8));
    endtask

    // Drive one clock cycle of stimulus and advance the scoreboard.
    task automatic cyc(input string tag, input logic wv, input logic [31:0] wd,
                       input logic re, input logic fl);
        bit pop_ok;
        bit push_ok;
        wr_valid = wv;
        wr_data  = wd;
        rd_en    = re;
        flush    = fl;
        #1;
        if (exp_q.size() > 0) check({tag, " head"}, rd_data, exp_q[0]);
        pop_ok  = re && (exp_q.size() > 0);
        push_ok = wv && ((exp_q.size() < 16) || pop_ok);
        @(posedge g_hclk_es1);
        #1;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        flush    = 1'b0;
        if (fl) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pop_ok) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(wd);
            if (wv && !push_ok) m_ovf = 1'b1;
            if (re && !pop_ok) m_unf = 1'b1;
        end
        check_status(tag);
    endtask

    initial begin
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        flush    = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        hreset_n = 1'b0;

        // Directed vectors: {wv, wd, re, fl, level, empty, full, ovf, unf, irq, chk_d, rd}.
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[1] = '{1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[2] = '{1'b1, 32'hA5A5_0003, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0002};
        vecs[4] = '{1'b1, 32'hA5A5_0004, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0003};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0004};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_1234, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state.
        repeat (2) @(posedge g_hclk_es1);
        #1;
        check("rst level", 32'(level), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst underflow", 32'(underflow), 32'd0);
        check("rst irq_level", 32'(irq_level), 32'd0);
        hreset_n = 1'b1;
        @(posedge g_hclk_es1);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_en    = vecs[i].re;
            flush    = vecs[i].fl;
            @(posedge g_hclk_es1);
            #1;
            wr_valid = 1'b0;
            rd_en    = 1'b0;
            flush    = 1'b0;
            check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].ful));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
            check($sformatf("vec%0d irq_level", i), 32'(irq_level), 32'(vecs[i].irq));
            if (vecs[i].chk_d) check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd);
        end

        // Threshold: 7 words gives irq low, the 8th raises it, one pop drops it.
        for (int i = 0; i < 8; i++) cyc("thr push", 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        cyc("thr pop", 1'b0, 32'h0, 1'b1, 1'b0);
        check("thr irq after pop", 32'(irq_level), 32'd0);

        // Fill to 16 words.
        for (int i = 8; i < 17; i++) cyc("fill", 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        check("fill full", 32'(full), 32'd1);

        // Simultaneous pop and push while full, across a pointer wrap.
        for (int i = 0; i < 20; i++) cyc("full pp", 1'b1, 32'h2000_0000 + 32'(i), 1'b1, 1'b0);
        check("full pp no overflow", 32'(overflow), 32'd0);

        // Push while full without a pop: the word is dropped and overflow is set.
        cyc("ovf push", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("ovf sticky", 32'(overflow), 32'd1);

        // Drain everything. Order is checked, and 0xDEADBEEF must never appear.
        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Level 10 with overflow still sticky, then flush together with push and pop.
        for (int i = 0; i < 10; i++) cyc("ten", 1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
        cyc("flush pp", 1'b1, 32'h4444_4444, 1'b1, 1'b1);
        check("flush level", 32'(level), 32'd0);

        // Reset mid-stream, with wr_valid held high.
        for (int i = 0; i < 3; i++) cyc("pre rst", 1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 32'h6666_6666;
        hreset_n = 1'b0;
        #1;
        check("async rst level", 32'(level), 32'd0);
        check("async rst empty", 32'(empty), 32'd1);
        @(posedge g_hclk_es1);
        #1;
        check("held rst level", 32'(level), 32'd0);
        wr_valid = 1'b0;
        hreset_n = 1'b1;
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        cyc("post rst", 1'b1, 32'h7777_0001, 1'b0, 1'b0);
        cyc("post rst pop", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
